uart_rx: RTL and testbench

Receive-side UART front end for the chip's console: consumes the top-level serial input `rxd`, recovers 8N1 frames with 16x oversampling, and buffers received bytes in a small FIFO. Sits between the board pin and the on-chip peripheral bus slave that drains bytes over a valid/ready handshake. Reports framing and overrun errors, and optionally parity errors, as one-cycle pulses.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_rx console receiver.
package uart_pkg;

   localparam int OVS_RATE   = 16;
   localparam int SAMPLE_IDX = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_e;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head word is visible while valid_o is high.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_i,
   input  logic [WIDTH-1:0]            push_data_i,
   input  logic                        pop_i,
   output logic [WIDTH-1:0]            head_o,
   output logic                        valid_o,
   output logic                        full_o,
   output logic [cnt_width(DEPTH)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             do_push;
   logic             do_pop;

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && valid_o;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with FWFT byte FIFO and one-cycle error pulses.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err; otherwise 8N1.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVS_DIV    = 109,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rxd,
   output logic [7:0]                       rx_data,
   output logic                             rx_valid,
   input  logic                             rx_ready,
   output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count,
   output logic                             frame_err,
   output logic                             overrun_err,
   output logic                             parity_err
);

   localparam int OSW = $clog2(OVS_RATE);

   logic            sync1_q, sync2_q, rxd_prev_q;
   logic [15:0]     tick_cnt_q;
   logic [OSW-1:0]  os_q;
   rx_state_e       state_q;
   logic [2:0]      bit_cnt_q;
   logic [7:0]      shift_q;
   logic            par_pend_q;
   logic            frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
   logic            parity_err_q;
`endif
   logic            tick, sample, fall, push, pop, fifo_full;

   assign tick   = (tick_cnt_q == 16'(OVS_DIV - 1));
   assign sample = tick && (os_q == OSW'(SAMPLE_IDX));
   assign fall   = rxd_prev_q && !sync2_q;
   assign pop    = rx_valid && rx_ready;
   // Good stop bit is pushed in the sampling cycle so the byte is visible one edge later.
   assign push   = sample && (state_q == ST_STOP) && sync2_q && !par_pend_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         rxd_prev_q  <= 1'b1;
         tick_cnt_q  <= '0;
         os_q        <= '0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_pend_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync1_q     <= rxd;
         sync2_q     <= sync1_q;
         rxd_prev_q  <= sync2_q;
         tick_cnt_q  <= tick ? '0 : tick_cnt_q + 16'd1;
         if (tick) os_q <= os_q + OSW'(1);
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  state_q    <= ST_START;
                  tick_cnt_q <= '0;
                  os_q       <= '0;
               end
            end
            ST_START: begin
               if (sample) begin
                  state_q    <= sync2_q ? ST_IDLE : ST_DATA;
                  bit_cnt_q  <= '0;
                  par_pend_q <= 1'b0;
               end
            end
            ST_DATA: begin
               if (sample) begin
                  shift_q   <= {sync2_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (sample) begin
                  par_pend_q <= ^{shift_q, sync2_q};
                  state_q    <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (sample) begin
                  if (sync2_q) begin
                     overrun_q <= push && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
                     parity_err_q <= par_pend_q;
`endif
                     state_q <= ST_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_WAIT_IDLE;
                  end
               end
            end
            ST_WAIT_IDLE: begin
               if (sync2_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (shift_q),
      .pop_i       (rx_ready),
      .head_o      (rx_data),
      .valid_o     (rx_valid),
      .full_o      (fifo_full),
      .count_o     (fifo_count)
   );

   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with OVS_DIV=4 (64 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DEPTH      = 16;
   localparam int BIT_CYC    = 64;
   // Pin edge to bit-centre sampling edge: 2 sync + 1 edge detect + 8 ticks of 4 clk.
   localparam int SAMPLE_OFF = 35;
   localparam int NVEC       = 24;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [4:0] fifo_count;
   logic       frame_err, overrun_err, parity_err;

   int checks   = 0;
   int failures = 0;
   int n_ferr = 0, n_ovr = 0, n_perr = 0;
   int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
   logic [7:0] model_q[$];

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      int         stop_low;
      int         exp_count;
      int         exp_ferr;
      int         exp_ovr;
      int         exp_perr;
   } vec_t;
   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   uart_rx #(
      .OVS_DIV    (4),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rxd         (rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .fifo_count  (fifo_count),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err)
   );

   // Counting high cycles also catches pulses wider than one clock.
   always @(negedge clk) begin
      if (!rst) begin
         n_ferr += int'(frame_err);
         n_ovr  += int'(overrun_err);
         n_perr += int'(parity_err);
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: a frame's fate follows directly from the stop level, parity and occupancy.
   task automatic model_frame(input logic [7:0] d, input bit bad_par, input int stop_low,
                              input bit pop_at_push);
      if (stop_low > 0) begin
         exp_ferr++;
      end else if (PAR && bad_par) begin
         exp_perr++;
      end else begin
         if (pop_at_push && model_q.size() > 0) model_q.delete(0);
         if (model_q.size() >= DEPTH) exp_ovr++;
         else model_q.push_back(d);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input int stop_low,
                             input bit pop_at_push, output logic v_before, output logic v_after);
      logic [10:0] lv;
      int n;
      lv     = '1;
      lv[0]  = 1'b0;
      lv[8:1] = d;
      n      = 9;
      if (PAR) begin
         lv[9] = (^d) ^ bad_par;
         n     = 10;
      end
      for (int i = 0; i < n; i++) begin
         rxd = lv[i];
         repeat (BIT_CYC) @(posedge clk);
         #1;
      end
      v_before = 1'b0;
      v_after  = 1'b0;
      if (stop_low > 0) begin
         rxd = 1'b0;
         repeat (BIT_CYC * stop_low) @(posedge clk);
         #1;
         rxd = 1'b1;
         repeat (BIT_CYC) @(posedge clk);
         #1;
      end else begin
         rxd = 1'b1;
         repeat (SAMPLE_OFF - 1) @(posedge clk);
         #1;
         v_before = rx_valid;
         if (pop_at_push) rx_ready = 1'b1;
         @(posedge clk);
         #1;
         v_after  = rx_valid;
         rx_ready = 1'b0;
         repeat (BIT_CYC - SAMPLE_OFF) @(posedge clk);
         #1;
      end
      $display("frame data=0x%02h bad_par=%0d stop_low=%0d pop=%0d count=%0d",
               d, bad_par, stop_low, pop_at_push, fifo_count);
   endtask

   task automatic frame(input logic [7:0] d, input bit bad_par, input int stop_low,
                        input bit pop_at_push);
      logic vb, va;
      model_frame(d, bad_par, stop_low, pop_at_push);
      send_frame(d, bad_par, stop_low, pop_at_push, vb, va);
   endtask

   task automatic check_state(input string tag);
      check({tag, " count"}, fifo_count, model_q.size());
      check({tag, " frame_err"}, n_ferr, exp_ferr);
      check({tag, " overrun"}, n_ovr, exp_ovr);
      check({tag, " parity_err"}, n_perr, exp_perr);
   endtask

   task automatic drain(input string tag);
      while (model_q.size() > 0) begin
         check({tag, " valid"}, rx_valid, 1);
         check({tag, " data"}, rx_data, model_q[0]);
         rx_ready = 1'b1;
         @(posedge clk);
         #1;
         rx_ready = 1'b0;
         model_q.delete(0);
      end
      check({tag, " empty"}, rx_valid, 0);
      check({tag, " drained count"}, fifo_count, 0);
   endtask

   initial begin
      logic vb, va;
      rst      = 1'b1;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("reset valid", rx_valid, 0);
      check("reset data", rx_data, 0);
      check("reset count", fifo_count, 0);
      check("reset errs", {frame_err, overrun_err, parity_err}, 0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // First byte with exact push latency.
      model_frame(8'hA5, 1'b0, 0, 1'b0);
      send_frame(8'hA5, 1'b0, 0, 1'b0, vb, va);
      check("A5 valid before push", vb, 0);
      check("A5 valid after push", va, 1);
      check("A5 data", rx_data, 8'hA5);
      check_state("A5");
      drain("A5");

      // Short low glitch on an idle line.
      rxd = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rxd = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check_state("glitch");

      // Broken stop bit followed by a good frame.
      frame(8'h3C, 1'b0, 3, 1'b0);
      check_state("3C frame_err");
      frame(8'h55, 1'b0, 0, 1'b0);
      check_state("55 after break");
      drain("55");

      // Fill past capacity, then push into a full FIFO while popping.
      for (int i = 0; i <= 16; i++) frame(8'(i), 1'b0, 0, 1'b0);
      check_state("overrun fill");
      frame(8'h11, 1'b0, 0, 1'b1);
      check_state("full push+pop");
      drain("wrap drain");

`ifdef UART_RX_PARITY_EN
      frame(8'h07, 1'b1, 0, 1'b0);
      check_state("07 bad parity");
      frame(8'h07, 1'b0, 0, 1'b0);
      check_state("07 good parity");
      drain("parity");
`endif

      // Randomized table: expectations are computed before anything is sent.
      for (int i = 0; i < NVEC; i++) begin
         vecs[i].data     = 8'($urandom_range(0, 255));
         vecs[i].bad_par  = PAR && ($urandom_range(0, 3) == 0);
         vecs[i].stop_low = ($urandom_range(0, 4) == 0) ? 1 : 0;
         model_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop_low, 1'b0);
         vecs[i].exp_count = model_q.size();
         vecs[i].exp_ferr  = exp_ferr;
         vecs[i].exp_ovr   = exp_ovr;
         vecs[i].exp_perr  = exp_perr;
      end
      for (int i = 0; i < NVEC; i++) begin
         send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop_low, 1'b0, vb, va);
         check($sformatf("vec%0d count", i), fifo_count, vecs[i].exp_count);
         check($sformatf("vec%0d frame_err", i), n_ferr, vecs[i].exp_ferr);
         check($sformatf("vec%0d overrun", i), n_ovr, vecs[i].exp_ovr);
         check($sformatf("vec%0d parity_err", i), n_perr, vecs[i].exp_perr);
      end
      drain("random drain");

      // Reset in the middle of a frame with a byte already buffered.
      frame(8'h99, 1'b0, 0, 1'b0);
      check_state("99 before reset");
      rxd = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      model_q.delete();
      check("midreset valid", rx_valid, 0);
      check("midreset count", fifo_count, 0);
      check("midreset data", rx_data, 0);
      repeat (3) @(posedge clk);
      #1;
      rxd = 1'b1;
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      frame(8'h42, 1'b0, 0, 1'b0);
      check_state("42 after reset");
      drain("42");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
